fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00003000: PC loaded on reset.
REQ-002 SHALL have parameter EXC_VEC, default 32'h00004180: exception handler entry PC.
REQ-003 SHALL have parameter PC_LO, default 32'h00003000: lowest legal fetch address.
REQ-004 SHALL have parameter PC_HI, default 32'h00004ffc: highest legal fetch address.
REQ-005 SHALL have port clk  input  1  clock, all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port imem_req  output  1  instruction memory request.
REQ-008 SHALL have port imem_addr  output  32  instruction memory byte address.
REQ-009 SHALL have port imem_ack  input  1  memory completion; imem_rdata valid in the same cycle.
REQ-010 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-011 SHALL have port exc_req  input  1  exception redirect to EXC_VEC.
REQ-012 SHALL have port eret_req  input  1  return redirect to epc.
REQ-013 SHALL have port epc  input  32  eret target.
REQ-014 SHALL have port br_taken  input  1  branch/jump redirect to br_target.
REQ-015 SHALL have port br_target  input  32  branch/jump target.
REQ-016 SHALL have port stall  input  1  downstream cannot accept the instruction this cycle.
REQ-017 SHALL have port if_valid  output  1  if_instr/if_pc/if_adel valid.
REQ-018 SHALL have port if_instr  output  32  delivered instruction; 0 when if_adel=1.
REQ-019 SHALL have port if_pc  output  32  PC of the delivered instruction.
REQ-020 SHALL have port if_adel  output  1  fetch address error flag for the delivered slot.

Function
REQ-021 SHALL implement states FETCH, HOLD, DROP; imem_req=1 in FETCH and DROP only; if_valid=1 in HOLD only.
REQ-022 SHALL drive imem_addr=pc in FETCH and hold the stale address in DROP until imem_ack.
REQ-023 SHALL treat pc as bad when pc[1:0]!=0, pc<PC_LO, or pc>PC_HI (unsigned).
REQ-024 SHALL, in FETCH with bad pc, issue no request (imem_req=0) and go to HOLD with if_instr=0, if_adel=1, if_pc=pc.
REQ-025 SHALL, in FETCH with good pc and imem_ack=1 and no redirect, latch if_instr=imem_rdata, if_pc=pc, if_adel=0, and go to HOLD.
REQ-026 SHALL, in FETCH with no imem_ack, hold imem_req and imem_addr stable.
REQ-027 SHALL, in HOLD with stall=0, consume the slot: pc<=pc+4 (wrap modulo 2^32), go to FETCH.
REQ-028 SHALL, in HOLD with stall=1, keep all if_* outputs unchanged.
REQ-029 SHALL resolve redirects with priority exc_req > eret_req > br_taken; target EXC_VEC, epc, br_target respectively.
REQ-030 SHALL apply a redirect regardless of stall: discard any held or arriving instruction, pc<=target.
REQ-031 SHALL, on redirect in FETCH with imem_ack=0 and good pc, go to DROP; otherwise go to FETCH.
REQ-032 SHALL, in DROP, discard imem_rdata on imem_ack and go to FETCH at the updated pc.
REQ-033 SHALL, on a redirect while in DROP, overwrite pc with the new target and stay in DROP.
REQ-034 SHALL deliver each accepted instruction exactly once; minimum fetch-to-valid latency 1 cycle after ack.

Reset
REQ-035 SHALL, on a clock edge with reset=1, set state=FETCH, pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_adel=0, overriding all other inputs.
REQ-036 SHALL rely on the instruction memory sharing the same reset, so no ack from a pre-reset request arrives afterwards.

Verification
REQ-037 SHALL cover: reset, ack every first FETCH cycle, stall=0 -> if_pc 0x3000, 0x3004, 0x3008 delivered every 2nd cycle, if_adel=0.
REQ-038 SHALL cover: stall=1 for 3 cycles in HOLD at if_pc 0x3004 -> outputs frozen, no new imem_req, next fetch 0x3008.
REQ-039 SHALL cover: br_taken=1 target 0x3100 while FETCH at 0x3008 waits ack -> DROP, stale ack discarded, next if_pc 0x3100.
REQ-040 SHALL cover: exc_req and br_taken same cycle -> next fetch at 0x00004180.
REQ-041 SHALL cover: eret_req with epc=0x3002 -> no imem_req, if_valid=1, if_adel=1, if_instr=0, if_pc=0x3002.
REQ-042 SHALL cover: reset asserted in HOLD with stall=1 -> if_valid=0, next imem_addr 0x3000.

Source files
------------

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction fetch front end. It issues one instruction-memory request at a
// time, holds the fetched word in a single output slot until downstream
// consumes it, and handles redirects (exception, exception return,
// branch/jump). It also flags fetches from misaligned or out-of-window
// addresses instead of sending them to memory.
//
// States:
//   FETCH - request imem at pc (unless pc is illegal) and wait for the ack
//   HOLD  - slot is valid; wait for downstream to take it (stall=0)
//   DROP  - a redirect overtook an outstanding request; keep that request
//           alive at its original address and throw the data away on ack
//
// Ports:
//   clk         in   1   clock, rising edge
//   reset       in   1   synchronous, active-high reset
//   imem_req    out  1   instruction memory request
//   imem_addr   out  32  instruction memory byte address
//   imem_ack    in   1   memory completion (imem_rdata valid same cycle)
//   imem_rdata  in   32  fetched instruction word
//   exc_req     in   1   redirect to EXC_VEC (highest priority)
//   eret_req    in   1   redirect to epc
//   epc         in   32  exception return target
//   br_taken    in   1   redirect to br_target (lowest priority)
//   br_target   in   32  branch/jump target
//   stall       in   1   downstream cannot accept the slot this cycle
//   if_valid    out  1   if_instr/if_pc/if_adel valid
//   if_instr    out  32  delivered instruction (0 on address error)
//   if_pc       out  32  PC of the delivered instruction
//   if_adel     out  1   fetch address error for the delivered slot
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
    parameter logic [31:0] PC_LO    = 32'h0000_3000,
    parameter logic [31:0] PC_HI    = 32'h0000_4ffc
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_adel
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] stale_addr, stale_addr_next;  // address of the request being dropped
    logic [31:0] if_instr_next, if_pc_next;
    logic        if_adel_next;

    logic        pc_bad;
    logic        redirect;
    logic [31:0] redirect_pc;

    // Illegal fetch address: misaligned or outside [PC_LO, PC_HI] (unsigned).
    assign pc_bad = (pc[1:0] != 2'b00) || (pc < PC_LO) || (pc > PC_HI);

    // Redirect priority: exception > exception return > branch.
    assign redirect    = exc_req | eret_req | br_taken;
    assign redirect_pc = exc_req  ? EXC_VEC :
                         eret_req ? epc     : br_target;

    // -------------------------------------------------------------------------
    // State register (with the pc / slot datapath registers)
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            stale_addr <= '0;
            if_instr   <= '0;
            if_pc      <= '0;
            if_adel    <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            stale_addr <= stale_addr_next;
            if_instr   <= if_instr_next;
            if_pc      <= if_pc_next;
            if_adel    <= if_adel_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a hold-value default first, so no path through
    // the case statement leaves one unassigned (which would infer a latch).
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        stale_addr_next = stale_addr;
        if_instr_next   = if_instr;
        if_pc_next      = if_pc;
        if_adel_next    = if_adel;

        unique case (state)
            FETCH: begin
                if (redirect) begin
                    pc_next = redirect_pc;
                    // A request is in flight only for a legal pc without ack;
                    // its late ack must be absorbed in DROP.
                    if (!pc_bad && !imem_ack) begin
                        state_next      = DROP;
                        stale_addr_next = pc;
                    end
                end else if (pc_bad) begin
                    state_next    = HOLD;
                    if_instr_next = '0;
                    if_pc_next    = pc;
                    if_adel_next  = 1'b1;
                end else if (imem_ack) begin
                    state_next    = HOLD;
                    if_instr_next = imem_rdata;
                    if_pc_next    = pc;
                    if_adel_next  = 1'b0;
                end
            end

            HOLD: begin
                // Redirect discards the held slot even while stalled.
                if (redirect) begin
                    pc_next    = redirect_pc;
                    state_next = FETCH;
                end else if (!stall) begin
                    pc_next    = pc + 32'd4;
                    state_next = FETCH;
                end
            end

            DROP: begin
                // A newer redirect only retargets pc; the stale request is
                // still outstanding. Its ack ends the drop even when it lands
                // together with that redirect.
                if (redirect) begin
                    pc_next = redirect_pc;
                end
                if (imem_ack) begin
                    state_next = FETCH;
                end
            end

            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        if_valid  = 1'b0;

        unique case (state)
            FETCH: imem_req = !pc_bad;
            HOLD:  if_valid = 1'b1;
            DROP: begin
                imem_req  = 1'b1;
                imem_addr = stale_addr;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

endmodule
